// File: rtl/multiplicador_if.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_if
//  Brief    : Start/busy/done handshake and operand/result bus of the
//             sequential multiply-accumulate unit.
//  Revision : 1.0
// ============================================================================
interface multiplicador_if #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
);
   logic              start;
   logic [W-1:0]      A;
   logic [W-1:0]      B;
   logic [W-1:0]      C;
   logic [2*W-1:0]    Producto;
   logic              busy;
   logic              done;
   logic [CW-1:0]     conta;

   modport master (
      output start, A, B, C,
      input  Producto, busy, done, conta
   );

   modport slave (
      input  start, A, B, C,
      output Producto, busy, done, conta
   );
endinterface
`default_nettype wire

// File: rtl/multiplicador_secuencial.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_secuencial
//  Brief    : Unsigned shift-add multiply-accumulate, Producto = A*B + C,
//             one multiplier bit per clock, fixed W-cycle latency.
//  Revision : 1.0
// ============================================================================
module multiplicador_secuencial #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  wire              clk,
   input  wire              rst,
   multiplicador_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [2*W-1:0]    r_acc;
   logic [2*W-1:0]    r_mcand;
   logic [W-1:0]      r_mplier;
   logic [CW-1:0]     r_conta;
   logic [2*W-1:0]    r_producto;

   logic [2*W-1:0]    w_acc_sum;
   logic              w_last;
   logic              w_busy;
   logic              w_done;

   // The sum cannot carry out of 2W bits: worst case is 2^2W - 2^W.
   assign w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_last    = (r_conta == CW'(W - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_conta    <= '0;
         r_producto <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_acc    <= {{W{1'b0}}, bus.C};
                  r_mcand  <= {{W{1'b0}}, bus.A};
                  r_mplier <= bus.B;
                  r_conta  <= '0;
               end
            end
            S_CALC: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_conta  <= r_conta + CW'(1);
               if (w_last) begin
                  r_producto <= w_acc_sum;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.Producto = r_producto;
   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.conta    = r_conta;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_secuencial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplicador_secuencial
//  Brief    : Directed vector bench for the sequential multiply-accumulate.
//  Revision : 1.0
// ============================================================================
module tb_multiplicador_secuencial;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   multiplicador_if #(.W(8)) bus ();

   multiplicador_secuencial #(.W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Launch from IDLE, scramble the inputs after acceptance, then verify
   // latency, busy length, result, conta and the hold after returning to IDLE.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [15:0] exp,
                        input string tag);
      int cyc;
      int busy_cnt;
      bus.A     = a;
      bus.B     = b;
      bus.C     = c;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.B     = ~b;
      bus.C     = ~c;
      busy_cnt  = bus.busy ? 1 : 0;
      cyc       = 0;
      while (!bus.done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.busy) busy_cnt++;
      end
      check({tag, " latency"}, cyc, 8);
      check({tag, " busy_cycles"}, busy_cnt, 8);
      check({tag, " Producto"}, int'(bus.Producto), int'(exp));
      check({tag, " conta_at_done"}, int'(bus.conta), 8);
      @(posedge clk); #1;
      check({tag, " done_cleared"}, int'(bus.done), 0);
      check({tag, " Producto_hold"}, int'(bus.Producto), int'(exp));
   endtask

   initial begin
      int cyc;
      int n;
      int t_done [3];
      int done_seen;

      checks = 0;
      errors = 0;

      vecs[0] = '{8'd4,   8'd2,   8'd0,   16'd8};
      vecs[1] = '{8'd1,   8'd1,   8'd0,   16'd1};
      vecs[2] = '{8'd4,   8'd2,   8'd1,   16'd9};
      vecs[3] = '{8'd3,   8'd43,  8'd27,  16'd156};
      vecs[4] = '{8'd255, 8'd255, 8'd255, 16'd65280};
      vecs[5] = '{8'd0,   8'd0,   8'd0,   16'd0};
      vecs[6] = '{8'd17,  8'd0,   8'd200, 16'd200};
      vecs[7] = '{8'd128, 8'd129, 8'd7,   16'd16519};

      // Reset with start asserted: reset must win.
      rst       = 1'b0;
      bus.start = 1'b1;
      bus.A     = 8'd9;
      bus.B     = 8'd9;
      bus.C     = 8'd9;
      repeat (3) @(posedge clk);
      #1;
      check("reset Producto", int'(bus.Producto), 0);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset conta", int'(bus.conta), 0);
      rst       = 1'b1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("idle busy", int'(bus.busy), 0);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp,
               $sformatf("vec%0d", i));
      end

      // start held high: one result every 10 cycles.
      bus.A     = 8'd5;
      bus.B     = 8'd5;
      bus.C     = 8'd0;
      bus.start = 1'b1;
      cyc = 0;
      n   = 0;
      while (n < 3 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.done) begin
            t_done[n] = cyc;
            check($sformatf("held Producto%0d", n), int'(bus.Producto), 25);
            n++;
         end
      end
      check("held pulse_count", n, 3);
      check("held first_done", t_done[0], 9);
      check("held period01", t_done[1] - t_done[0], 10);
      check("held period12", t_done[2] - t_done[1], 10);
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("held back_idle_busy", int'(bus.busy), 0);
      check("held Producto_hold", int'(bus.Producto), 25);

      // Abort by reset at CALC step 4.
      bus.A     = 8'd200;
      bus.B     = 8'd100;
      bus.C     = 8'd0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort conta_before", int'(bus.conta), 4);
      check("abort busy_before", int'(bus.busy), 1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort Producto", int'(bus.Producto), 0);
      check("abort busy", int'(bus.busy), 0);
      check("abort conta", int'(bus.conta), 0);
      check("abort done", int'(bus.done), 0);
      rst = 1'b1;
      done_seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done) done_seen++;
      end
      check("abort no_done", done_seen, 0);
      check("abort idle_Producto", int'(bus.Producto), 0);
      do_op(8'd200, 8'd100, 8'd0, 16'd20000, "relaunch");

      // Idle hold over several cycles between operations.
      repeat (5) @(posedge clk);
      #1;
      check("idle_hold Producto", int'(bus.Producto), 20000);
      check("idle_hold conta", int'(bus.conta), 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
